// File: rtl/fpc_pkg.sv
// Shared types and constants for the FP16 calculator host.
package fpc_pkg;

   typedef logic [15:0] fp16_t;

   localparam logic  MODE_ADD  = 1'b0;
   localparam logic  MODE_MUL  = 1'b1;
   localparam fp16_t FP16_QNAN = 16'h7E00;

   // One queued calculator job: operands plus operation select.
   typedef struct packed {
      fp16_t a;
      fp16_t b;
      logic  mode;
   } fpc_job_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      HOLD
   } fpc_host_state_e;

endpackage

// File: rtl/fpc_host_if.sv
// Job, calculator and result ports of the FP16 calculator host.
// slave is the host's view; master is the view of whatever drives it.
interface fpc_host_if;
   import fpc_pkg::*;

   // Job source (valid/ready)
   logic  job_valid;
   logic  job_ready;
   fp16_t job_a;
   fp16_t job_b;
   logic  job_mode;

   // Calculator side
   logic  fpc_in_valid;
   fp16_t fpc_in_a;
   fp16_t fpc_in_b;
   logic  fpc_mode;
   logic  fpc_out_valid;
   fp16_t fpc_out;

   // Result sink (valid/ready) and status
   logic  res_valid;
   logic  res_ready;
   fp16_t res_data;
   logic  res_mode;
   logic  res_err;
   logic  spurious;

   modport slave (
      input  job_valid, job_a, job_b, job_mode,
      input  fpc_out_valid, fpc_out,
      input  res_ready,
      output job_ready,
      output fpc_in_valid, fpc_in_a, fpc_in_b, fpc_mode,
      output res_valid, res_data, res_mode, res_err, spurious
   );

   modport master (
      output job_valid, job_a, job_b, job_mode,
      output fpc_out_valid, fpc_out,
      output res_ready,
      input  job_ready,
      input  fpc_in_valid, fpc_in_a, fpc_in_b, fpc_mode,
      input  res_valid, res_data, res_mode, res_err, spurious
   );

endinterface

// File: rtl/fpc_job_fifo.sv
// Small synchronous FIFO holding pending calculator jobs.
// Head entry is visible combinationally from registered storage.
module fpc_job_fifo
   import fpc_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_push,
   input  fpc_job_t i_push_data,
   input  logic     i_pop,
   output fpc_job_t o_head,
   output logic     o_full,
   output logic     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fpc_job_t      r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Never write when full or read when empty, whatever the caller asks.
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // Job storage write.
   // NOTE: storage has no reset; the count gates every read, so stale entries are never seen.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
   // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fpc_host.sv
// Initiator for the FP16 calculator: queues jobs, issues one at a time,
// waits for the result under a watchdog and holds it until accepted.
module fpc_host
   import fpc_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 8
)
(
   input  logic       clk,
   input  logic       rst_n,
   fpc_host_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT);

   fpc_host_state_e r_state;
   fpc_host_state_e w_next_state;
   logic            w_pop;
   logic            w_push;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   fpc_job_t        w_fifo_head;
   logic            w_cnt_last;
   logic [CNT_W-1:0] r_cnt;

   fp16_t r_fpc_in_a;
   fp16_t r_fpc_in_b;
   logic  r_fpc_mode;
   fp16_t r_res_data;
   logic  r_res_mode;
   logic  r_res_err;
   logic  r_spurious;

   assign w_push     = bus.job_valid && !w_fifo_full;
   assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

   fpc_job_fifo #(
      .DEPTH (DEPTH)
   ) u_job_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_data ({bus.job_a, bus.job_b, bus.job_mode}),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   // Every output comes from a register or the state register alone.
   assign bus.job_ready    = !w_fifo_full;
   assign bus.fpc_in_valid = (r_state == ISSUE);
   assign bus.fpc_in_a     = r_fpc_in_a;
   assign bus.fpc_in_b     = r_fpc_in_b;
   assign bus.fpc_mode     = r_fpc_mode;
   assign bus.res_valid    = (r_state == HOLD);
   assign bus.res_data     = r_res_data;
   assign bus.res_mode     = r_res_mode;
   assign bus.res_err      = r_res_err;
   assign bus.spurious     = r_spurious;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and FIFO pop; a valid response beats the watchdog.
   // NOTE: defaults come first so no path through the case can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_next_state = ISSUE;
               w_pop        = 1'b1;
            end
         end
         ISSUE: begin
            w_next_state = WAIT;
         end
         WAIT: begin
            if (bus.fpc_out_valid || w_cnt_last) begin
               w_next_state = HOLD;
            end
         end
         HOLD: begin
            if (bus.res_ready) begin
               if (!w_fifo_empty) begin
                  w_next_state = ISSUE;
                  w_pop        = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Latch the head job into the calculator drive registers on pop; held afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fpc_in_a <= '0;
         r_fpc_in_b <= '0;
         r_fpc_mode <= 1'b0;
      end else if (w_pop) begin
         r_fpc_in_a <= w_fifo_head.a;
         r_fpc_in_b <= w_fifo_head.b;
         r_fpc_mode <= w_fifo_head.mode;
      end
   end

   // Watchdog: cleared while issuing, counts WAIT cycles without a response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_cnt <= '0;
      end else if ((r_state == WAIT) && !bus.fpc_out_valid && !w_cnt_last) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Result capture on response or timeout; held untouched through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_data <= '0;
         r_res_mode <= 1'b0;
         r_res_err  <= 1'b0;
      end else if (r_state == WAIT) begin
         if (bus.fpc_out_valid) begin
            r_res_data <= bus.fpc_out;
            r_res_mode <= r_fpc_mode;
            r_res_err  <= 1'b0;
         end else if (w_cnt_last) begin
            r_res_data <= FP16_QNAN;
            r_res_mode <= r_fpc_mode;
            r_res_err  <= 1'b1;
         end
      end
   end

   // Sticky flag for calculator strobes that arrive while nothing is awaited.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_spurious <= 1'b0;
      end else if (bus.fpc_out_valid && (r_state != WAIT)) begin
         r_spurious <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fpc_host.sv
// Self-checking bench for fpc_host: directed scenarios plus a randomized run,
// checked against a queue-based job/result model and a stub calculator.
module tb_fpc_host;
   import fpc_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;
   localparam int N_RAND  = 40;

   typedef struct packed {
      fp16_t data;
      logic  mode;
      logic  err;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;

   fpc_host_if bus ();

   fpc_host #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Stub calculator: real answers for the directed operand pairs, a scramble otherwise.
   function automatic fp16_t calc_fn(input fpc_job_t j);
      if (j.a == 16'h3C00 && j.b == 16'h4000 && j.mode == MODE_ADD) return 16'h4200;
      if (j.a == 16'h4000 && j.b == 16'h4200 && j.mode == MODE_MUL) return 16'h4600;
      return j.a ^ {j.b[7:0], j.b[15:8]} ^ (j.mode ? 16'h5A5A : 16'h0000);
   endfunction

   // Reference model state
   fpc_job_t job_q [$];
   res_t     exp_q [$];
   int       issue_cnt = 0;
   int       res_cnt   = 0;

   // Calculator behaviour controls
   bit    calc_silent = 1'b0;
   int    calc_gap    = 2;
   bit    calc_rand   = 1'b0;
   bit    spur_req    = 1'b0;
   bit    pend        = 1'b0;
   int    pend_cnt    = 0;
   fp16_t pend_data   = '0;

   logic     prev_in_valid  = 1'b0;
   logic     prev_res_valid = 1'b0;
   logic     prev_res_ready = 1'b0;
   res_t     prev_res       = '0;
   fpc_job_t m_head;
   res_t     m_exp;
   bit       m_silent;
   int       m_gap;

   // Monitor at negedge, calculator drive just after posedge.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            job_q.delete();
            exp_q.delete();
            pend           = 1'b0;
            prev_in_valid  = 1'b0;
            prev_res_valid = 1'b0;
            prev_res_ready = 1'b0;
         end else begin
            if (bus.res_valid && prev_res_valid && !prev_res_ready)
               check("res_hold", {bus.res_data, bus.res_mode, bus.res_err}, prev_res);
            if (bus.res_valid && bus.res_ready) begin
               res_cnt++;
               check("res_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0)
                  check("res_order", {bus.res_data, bus.res_mode, bus.res_err}, exp_q.pop_front());
            end
            if (bus.fpc_in_valid) begin
               issue_cnt++;
               check("issue_pulse", prev_in_valid, 0);
               check("issue_not_in_hold", bus.res_valid, 0);
               check("issue_has_job", job_q.size() > 0, 1);
               if (job_q.size() > 0) begin
                  m_head = job_q.pop_front();
                  check("issue_job", {bus.fpc_in_a, bus.fpc_in_b, bus.fpc_mode}, m_head);
                  m_silent = calc_silent;
                  m_gap    = calc_gap;
                  if (calc_rand) begin
                     m_silent = ($urandom_range(0, 4) == 0);
                     m_gap    = $urandom_range(1, TIMEOUT);
                  end
                  if (m_silent || m_gap > TIMEOUT)
                     m_exp = res_t'{FP16_QNAN, m_head.mode, 1'b1};
                  else
                     m_exp = res_t'{calc_fn(m_head), m_head.mode, 1'b0};
                  exp_q.push_back(m_exp);
                  if (!m_silent) begin
                     pend      = 1'b1;
                     pend_cnt  = m_gap;
                     pend_data = calc_fn(m_head);
                  end
               end
            end
            if (bus.job_valid && bus.job_ready)
               job_q.push_back(fpc_job_t'{bus.job_a, bus.job_b, bus.job_mode});
            prev_in_valid  = bus.fpc_in_valid;
            prev_res_valid = bus.res_valid;
            prev_res_ready = bus.res_ready;
            prev_res       = {bus.res_data, bus.res_mode, bus.res_err};
         end
         @(posedge clk);
         #1;
         bus.fpc_out_valid = 1'b0;
         if (spur_req) begin
            bus.fpc_out_valid = 1'b1;
            bus.fpc_out       = 16'hBEEF;
            spur_req          = 1'b0;
         end
         if (pend && rst_n) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               bus.fpc_out_valid = 1'b1;
               bus.fpc_out       = pend_data;
               pend              = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a job until accepted (bounded). Called just after a posedge.
   task automatic push_job(input fpc_job_t j);
      int guard = 0;
      bit acc   = 1'b0;
      bus.job_a     = j.a;
      bus.job_b     = j.b;
      bus.job_mode  = j.mode;
      bus.job_valid = 1'b1;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = bus.job_ready;
         guard++;
         tick();
      end
      bus.job_valid = 1'b0;
      check("push_accepted", acc, 1);
   endtask

   // Push into an empty host and count edges from acceptance to res_valid.
   task automatic timed_job(input fpc_job_t j, output int lat);
      bus.job_a     = j.a;
      bus.job_b     = j.b;
      bus.job_mode  = j.mode;
      bus.job_valid = 1'b1;
      @(negedge clk);
      check("timed_ready", bus.job_ready, 1);
      tick();
      bus.job_valid = 1'b0;
      lat = 0;
      while (!bus.res_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic wait_idle(input string tag);
      int guard = 0;
      while ((job_q.size() != 0 || exp_q.size() != 0 || pend || bus.res_valid) && guard < 300) begin
         tick();
         guard++;
      end
      check({tag, "_drained"}, guard < 300, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_valid"}, bus.fpc_in_valid, 0);
      check({tag, "_in_ops"}, {bus.fpc_in_a, bus.fpc_in_b, bus.fpc_mode}, 0);
      check({tag, "_res"}, {bus.res_valid, bus.res_data, bus.res_mode, bus.res_err}, 0);
      check({tag, "_spurious"}, bus.spurious, 0);
      check({tag, "_job_ready"}, bus.job_ready, 1);
   endtask

   int lat;
   int base;
   int n_acc;
   int cyc;
   bit acc;

   initial begin : stimulus
      rst_n             = 1'b0;
      bus.job_valid     = 1'b0;
      bus.job_a         = '0;
      bus.job_b         = '0;
      bus.job_mode      = 1'b0;
      bus.fpc_out_valid = 1'b0;
      bus.fpc_out       = '0;
      bus.res_ready     = 1'b1;
      #1;
      check_reset_outputs("reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // 1. Add with nominal latency
      timed_job(fpc_job_t'{16'h3C00, 16'h4000, MODE_ADD}, lat);
      check("t1_latency", lat, 4);
      check("t1_result", {bus.res_data, bus.res_mode, bus.res_err}, {16'h4200, 1'b0, 1'b0});
      wait_idle("t1");

      // 2. Multiply; calculator inputs hold the last issued job afterwards
      base = issue_cnt;
      timed_job(fpc_job_t'{16'h4000, 16'h4200, MODE_MUL}, lat);
      check("t2_latency", lat, 4);
      check("t2_result", {bus.res_data, bus.res_mode, bus.res_err}, {16'h4600, 1'b1, 1'b0});
      wait_idle("t2");
      check("t2_one_issue", issue_cnt - base, 1);
      check("t2_in_hold", {bus.fpc_in_valid, bus.fpc_in_a, bus.fpc_in_b, bus.fpc_mode},
            {1'b0, 16'h4000, 16'h4200, 1'b1});

      // 3. Backpressure: fill the FIFO behind a held result
      bus.res_ready = 1'b0;
      base = issue_cnt;
      for (int i = 0; i < DEPTH + 1; i++)
         push_job(fpc_job_t'{16'h1000 + 16'(i), 16'h2000 + 16'(i * 3), 1'(i)});
      @(negedge clk);
      check("t3_full_not_ready", bus.job_ready, 0);
      repeat (12) tick();
      check("t3_single_issue", issue_cnt - base, 1);
      check("t3_holding", bus.res_valid, 1);
      base = res_cnt;
      bus.res_ready = 1'b1;
      wait_idle("t3");
      check("t3_all_results", res_cnt - base, DEPTH + 1);
      check("t3_ready_again", bus.job_ready, 1);

      // 4a. Silent calculator -> timeout
      calc_silent = 1'b1;
      timed_job(fpc_job_t'{16'h3555, 16'h0123, MODE_ADD}, lat);
      check("t4a_latency", lat, TIMEOUT + 2);
      check("t4a_result", {bus.res_data, bus.res_err}, {FP16_QNAN, 1'b1});
      wait_idle("t4a");
      calc_silent = 1'b0;

      // 4b. Response on the last watchdog cycle wins
      calc_gap = TIMEOUT;
      timed_job(fpc_job_t'{16'h4400, 16'h3800, MODE_MUL}, lat);
      check("t4b_latency", lat, TIMEOUT + 2);
      check("t4b_result", {bus.res_data, bus.res_mode, bus.res_err},
            {calc_fn(fpc_job_t'{16'h4400, 16'h3800, MODE_MUL}), 1'b1, 1'b0});
      wait_idle("t4b");
      check("t4b_no_spurious", bus.spurious, 0);

      // 5. Strobe while idle
      @(negedge clk);
      spur_req = 1'b1;
      repeat (3) tick();
      check("t5_spurious_set", bus.spurious, 1);
      check("t5_no_result", bus.res_valid, 0);
      repeat (5) tick();
      check("t5_spurious_sticky", bus.spurious, 1);

      // 4c. Response one cycle too late -> timeout, late strobe ignored
      calc_gap = TIMEOUT + 1;
      timed_job(fpc_job_t'{16'h5000, 16'h5100, MODE_ADD}, lat);
      check("t4c_latency", lat, TIMEOUT + 2);
      check("t4c_result", {bus.res_data, bus.res_err}, {FP16_QNAN, 1'b1});
      wait_idle("t4c");
      check("t4c_idle_after_late", bus.res_valid, 0);
      calc_gap = 2;

      // Randomized traffic, backpressure and calculator timing
      calc_rand = 1'b1;
      n_acc = 0;
      cyc   = 0;
      while (n_acc < N_RAND && cyc < 5000) begin
         if (!bus.job_valid && $urandom_range(0, 2) != 0) begin
            bus.job_a     = 16'($urandom);
            bus.job_b     = 16'($urandom);
            bus.job_mode  = 1'($urandom);
            bus.job_valid = 1'b1;
         end
         bus.res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.job_valid && bus.job_ready;
         if (acc) n_acc++;
         tick();
         if (acc) bus.job_valid = 1'b0;
         cyc++;
      end
      bus.job_valid = 1'b0;
      bus.res_ready = 1'b1;
      wait_idle("rand");
      calc_rand = 1'b0;
      check("rand_accepted", n_acc, N_RAND);

      // 6. Reset in WAIT with two jobs queued
      calc_silent = 1'b1;
      push_job(fpc_job_t'{16'h0A0A, 16'h0B0B, MODE_ADD});
      push_job(fpc_job_t'{16'h0C0C, 16'h0D0D, MODE_MUL});
      push_job(fpc_job_t'{16'h0E0E, 16'h0F0F, MODE_ADD});
      repeat (2) tick();
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6_reset");
      repeat (2) tick();
      rst_n = 1'b1;
      calc_silent = 1'b0;
      base = issue_cnt;
      repeat (20) tick();
      check("t6_no_issue", issue_cnt - base, 0);
      check("t6_idle", {bus.res_valid, bus.job_ready, bus.spurious}, {1'b0, 1'b1, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
